// File: rtl/huff_pkg.sv
// Shared constants and state encoding for the canonical Huffman decode path.
package huff_pkg;

    localparam int MAX_LEN  = 16;
    localparam int SYM_W    = 8;
    localparam int TBL_SIZE = 256;
    localparam int CNT_W    = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUILD,
        S_FETCH,
        S_DECODE,
        S_LOOKUP,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/huff_decode_ctrl_if.sv
// Bitstream-in / symbol-out valid-ready channels of the Huffman decoder.
interface huff_decode_ctrl_if
    import huff_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 6
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [LEN_WIDTH:0]    in_nbits;

    logic                  out_valid;
    logic                  out_ready;
    logic [SYM_W-1:0]      out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_last, in_nbits, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbits, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/huff_canon_table.sv
// Canonical Huffman table: per-length counts, first_code/base built one length
// per cycle, symbol RAM, and the match/address compare for the current code.
module huff_canon_table
    import huff_pkg::*;
#(
    parameter int  MAX_LEN = huff_pkg::MAX_LEN,
    localparam int LW      = $clog2(MAX_LEN + 1),
    localparam int AW      = MAX_LEN + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tbl_we,
    input  logic               tbl_is_sym,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [CNT_W-1:0]   tbl_wdata,
    input  logic               build_go,
    input  logic               build_step,
    output logic               bld_last,
    output logic               bld_err,
    output logic               built,
    input  logic [LW-1:0]      code_len,
    input  logic [MAX_LEN-1:0] code,
    input  logic               addr_en,
    input  logic               rd_en,
    output logic               match,
    output logic [SYM_W-1:0]   sym_data
);

    localparam logic [SYM_W-1:0] MAX_ADDR  = SYM_W'(MAX_LEN);
    localparam logic [LW-1:0]    LAST_L    = LW'(MAX_LEN);
    localparam logic [AW-1:0]    TOTAL_MAX = AW'(TBL_SIZE);

    logic [CNT_W-1:0] cnt        [0:MAX_LEN];
    logic [AW-1:0]    first_code [0:MAX_LEN];
    logic [CNT_W-1:0] base       [0:MAX_LEN];
    logic [SYM_W-1:0] sym_ram    [0:TBL_SIZE-1];

    logic [LW-1:0]    bld_l;
    logic [AW-1:0]    fc_run;
    logic [AW-1:0]    sum_run;
    logic [AW-1:0]    fc_l;
    logic [AW-1:0]    total_l;
    logic [AW-1:0]    limit_l;
    logic [AW-1:0]    off;
    logic [CNT_W-1:0] addr_full;
    logic [SYM_W-1:0] ram_addr;
    logic             cnt_wr;

    assign cnt_wr = tbl_we && !tbl_is_sym && (tbl_addr != '0) && (tbl_addr <= MAX_ADDR);

    // fc_run holds first_code[l-1]; cnt[0] is never written so it stays zero.
    always_comb begin
        fc_l    = (fc_run + AW'(cnt[bld_l - 1'b1])) << 1;
        total_l = sum_run + AW'(cnt[bld_l]);
        limit_l = AW'(1) << bld_l;
    end

    assign bld_last = (bld_l == LAST_L);
    assign bld_err  = ((fc_l + AW'(cnt[bld_l])) > limit_l) || (total_l > TOTAL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MAX_LEN; i++) begin
                cnt[i]        <= '0;
                first_code[i] <= '0;
                base[i]       <= '0;
            end
            bld_l   <= '0;
            fc_run  <= '0;
            sum_run <= '0;
            built   <= 1'b0;
        end else begin
            if (cnt_wr) cnt[tbl_addr[LW-1:0]] <= tbl_wdata;
            if (tbl_we) built <= 1'b0;
            if (build_go) begin
                bld_l   <= LW'(1);
                fc_run  <= '0;
                sum_run <= '0;
                built   <= 1'b0;
            end else if (build_step) begin
                first_code[bld_l] <= fc_l;
                base[bld_l]       <= sum_run[CNT_W-1:0];
                fc_run            <= fc_l;
                sum_run           <= total_l;
                bld_l             <= bld_l + 1'b1;
                if (bld_last && !bld_err) built <= 1'b1;
            end
        end
    end

    // Codes below first_code wrap to a large offset and fail the compare.
    assign off       = AW'(code) - first_code[code_len];
    assign match     = (code_len != '0) && (off < AW'(cnt[code_len]));
    assign addr_full = base[code_len] + off[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (tbl_we && tbl_is_sym) sym_ram[tbl_addr] <= tbl_wdata[SYM_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            sym_data <= '0;
        end else begin
            if (addr_en) ram_addr <= addr_full[SYM_W-1:0];
            if (rd_en)   sym_data <= sym_ram[ram_addr];
        end
    end

endmodule

// File: rtl/huff_decode_ctrl.sv
// Huffman decode controller: pulls MSB-first bitstream words, walks codes one
// bit per cycle against the canonical table and emits 8-bit symbols.
module huff_decode_ctrl
    import huff_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 6,
    parameter int MAX_LEN    = huff_pkg::MAX_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tbl_we,
    input  logic               tbl_is_sym,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [CNT_W-1:0]   tbl_wdata,
    input  logic               tbl_build,
    huff_decode_ctrl_if.slave  io,
    output logic               busy,
    output logic               err
);

    localparam int                LW        = $clog2(MAX_LEN + 1);
    localparam logic [LEN_WIDTH:0] FULL_BITS = (LEN_WIDTH + 1)'(DATA_WIDTH);
    localparam logic [LW-1:0]     LAST_LEN  = LW'(MAX_LEN);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] sreg;
    logic [LEN_WIDTH:0]    bits_left;
    logic [LEN_WIDTH:0]    bl_nxt;
    logic                  last_q;
    logic [MAX_LEN-1:0]    acc;
    logic [MAX_LEN-1:0]    acc_nxt;
    logic [LW-1:0]         len;
    logic [LW-1:0]         len_nxt;
    logic                  err_q;

    logic ld_word, shift_bit, clr_code, set_err;
    logic build_go, build_step, addr_en, rd_en;
    logic bld_last, bld_err, built, match;
    logic [SYM_W-1:0] sym_data;

    assign acc_nxt = {acc[MAX_LEN-2:0], sreg[DATA_WIDTH-1]};
    assign len_nxt = len + 1'b1;
    assign bl_nxt  = bits_left - 1'b1;

    huff_canon_table #(.MAX_LEN(MAX_LEN)) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .tbl_we     (tbl_we && (state == S_IDLE)),
        .tbl_is_sym (tbl_is_sym),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .build_go   (build_go),
        .build_step (build_step),
        .bld_last   (bld_last),
        .bld_err    (bld_err),
        .built      (built),
        .code_len   (len_nxt),
        .code       (acc_nxt),
        .addr_en    (addr_en),
        .rd_en      (rd_en),
        .match      (match),
        .sym_data   (sym_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ld_word    = 1'b0;
        shift_bit  = 1'b0;
        clr_code   = 1'b0;
        set_err    = 1'b0;
        build_go   = 1'b0;
        build_step = 1'b0;
        addr_en    = 1'b0;
        rd_en      = 1'b0;
        if (!start) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tbl_build) begin
                        build_go  = 1'b1;
                        state_nxt = S_BUILD;
                    end else if (built && !tbl_we) begin
                        state_nxt = S_FETCH;
                    end
                end
                S_BUILD: begin
                    build_step = 1'b1;
                    if (bld_err) begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (bld_last) begin
                        state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (io.in_valid) begin
                        ld_word   = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    shift_bit = 1'b1;
                    if (match) begin
                        addr_en   = 1'b1;
                        state_nxt = S_LOOKUP;
                    end else if (len_nxt == LAST_LEN || (bl_nxt == '0 && last_q)) begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (bl_nxt == '0) begin
                        state_nxt = S_FETCH;
                    end
                end
                S_LOOKUP: begin
                    rd_en     = 1'b1;
                    state_nxt = S_EMIT;
                end
                S_EMIT: begin
                    if (io.out_ready) begin
                        clr_code = 1'b1;
                        if (last_q && bits_left == '0) state_nxt = S_DONE;
                        else if (bits_left == '0)      state_nxt = S_FETCH;
                        else                           state_nxt = S_DECODE;
                    end
                end
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Code accumulator survives FETCH so a code may straddle two words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            bits_left <= '0;
            last_q    <= 1'b0;
            acc       <= '0;
            len       <= '0;
            err_q     <= 1'b0;
        end else if (!start) begin
            sreg      <= '0;
            bits_left <= '0;
            last_q    <= 1'b0;
            acc       <= '0;
            len       <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ld_word) begin
                sreg      <= io.in_data;
                bits_left <= io.in_last ? io.in_nbits : FULL_BITS;
                last_q    <= io.in_last;
            end
            if (shift_bit) begin
                sreg      <= sreg << 1;
                acc       <= acc_nxt;
                len       <= len_nxt;
                bits_left <= bl_nxt;
            end
            if (clr_code) begin
                acc <= '0;
                len <= '0;
            end
            if (set_err) err_q <= 1'b1;
        end
    end

    assign io.in_ready  = (state == S_FETCH);
    assign io.out_valid = (state == S_EMIT);
    assign io.out_data  = sym_data;
    assign io.out_last  = (state == S_EMIT) && last_q && (bits_left == '0);
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_huff_decode_ctrl.sv
// Directed bench for huff_decode_ctrl with hand-computed symbol expectations.
module tb_huff_decode_ctrl;
    import huff_pkg::*;

    localparam int DW = 64;
    localparam int LW = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       tbl_we;
    logic       tbl_is_sym;
    logic [7:0] tbl_addr;
    logic [8:0] tbl_wdata;
    logic       tbl_build;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    huff_decode_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    huff_decode_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tbl_we     (tbl_we),
        .tbl_is_sym (tbl_is_sym),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .tbl_build  (tbl_build),
        .io         (bus),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_wr(input logic is_sym, input logic [7:0] addr, input logic [8:0] data);
        tbl_we     = 1'b1;
        tbl_is_sym = is_sym;
        tbl_addr   = addr;
        tbl_wdata  = data;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] data, input logic last, input logic [6:0] nbits);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_nbits = nbits;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp_data, input logic exp_last,
                        output int waited);
        waited = 0;
        while (!bus.out_valid && waited < 200) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"},  64'(bus.out_data),  64'(exp_data));
        chk({tag, "_last"},  64'(bus.out_last),  64'(exp_last));
        tick();
    endtask

    task automatic restart();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("restart_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          n;
        logic        seen;
        logic [7:0]  exp_sym [4];
        logic        exp_lst [4];
        int          exp_lat [4];

        exp_sym = '{8'h41, 8'h42, 8'h43, 8'h44};
        exp_lst = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_lat = '{2, 3, 4, 4};

        rst_n = 1'b0; start = 1'b0; tbl_we = 1'b0; tbl_is_sym = 1'b0;
        tbl_addr = '0; tbl_wdata = '0; tbl_build = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.in_nbits = '0; bus.out_ready = 1'b1;

        #23;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_err",       64'(err),           64'd0);
        rst_n = 1'b1;
        tick();

        // Table load: A=0, B=10, C=110, D=111
        start = 1'b1;
        tbl_wr(1'b0, 8'd1, 9'd1);
        tbl_wr(1'b0, 8'd2, 9'd1);
        tbl_wr(1'b0, 8'd3, 9'd2);
        for (int i = 0; i < 4; i++) tbl_wr(1'b1, 8'(i), {1'b0, exp_sym[i]});
        chk("idle_before_build", 64'(busy), 64'd0);
        tbl_build = 1'b1;
        tick();
        tbl_build = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("build_busy", 64'(busy), 64'd1);
            chk("build_no_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        chk("build_done_ready", 64'(bus.in_ready), 64'd1);

        send_word(64'h5B80_0000_0000_0000, 1'b1, 7'd9);
        for (int i = 0; i < 4; i++) begin
            recv("basic", exp_sym[i], exp_lst[i], w);
            chk("basic_latency", 64'(w), 64'(exp_lat[i]));
        end
        chk("basic_done_busy",  64'(busy),          64'd0);
        chk("basic_done_err",   64'(err),           64'd0);
        chk("basic_done_ready", 64'(bus.in_ready),  64'd0);
        chk("basic_done_valid", 64'(bus.out_valid), 64'd0);

        // Word span: 21 x "111" then a dangling "1" completed by "10"
        restart();
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd0);
        for (int i = 0; i < 21; i++) recv("span_d", 8'h44, 1'b0, w);
        send_word(64'h8000_0000_0000_0000, 1'b1, 7'd2);
        recv("span_c", 8'h43, 1'b1, w);
        chk("span_err",  64'(err),  64'd0);
        chk("span_busy", 64'(busy), 64'd0);

        // Backpressure on a single-symbol stream
        restart();
        bus.out_ready = 1'b0;
        send_word(64'h0, 1'b1, 7'd1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    64'(bus.out_valid), 64'd1);
            chk("bp_data",     64'(bus.out_data),  64'h41);
            chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        recv("bp_release", 8'h41, 1'b1, w);
        chk("bp_err", 64'(err), 64'd0);

        // Truncated stream "11"
        restart();
        send_word(64'hC000_0000_0000_0000, 1'b1, 7'd2);
        seen = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
            n++;
        end
        chk("trunc_no_symbol", 64'(seen), 64'd0);
        chk("trunc_err",       64'(err),  64'd1);
        chk("trunc_done",      64'(busy), 64'd0);
        start = 1'b0;
        tick();
        chk("trunc_clear_err", 64'(err),  64'd0);
        chk("trunc_idle",      64'(busy), 64'd0);

        // Mid-stream abort, then reuse the table without rebuilding
        start = 1'b1;
        tick();
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd0);
        chk("abort_decoding", 64'(busy), 64'd1);
        start = 1'b0;
        tick();
        chk("abort_idle",     64'(busy),          64'd0);
        chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_no_ready", 64'(bus.in_ready),  64'd0);
        start = 1'b1;
        tick();
        chk("abort_refetch", 64'(bus.in_ready), 64'd1);
        send_word(64'h5B80_0000_0000_0000, 1'b1, 7'd9);
        for (int i = 0; i < 4; i++) recv("fresh", exp_sym[i], exp_lst[i], w);
        chk("fresh_err", 64'(err), 64'd0);

        // Asynchronous reset while a symbol is held in EMIT
        restart();
        bus.out_ready = 1'b0;
        send_word(64'h0, 1'b1, 7'd1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("arst_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy",  64'(busy),          64'd0);
        chk("arst_data",  64'(bus.out_data),  64'd0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Oversubscribed table: three codes of length 1
        tbl_wr(1'b0, 8'd1, 9'd3);
        tbl_build = 1'b1;
        tick();
        tbl_build = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) seen = 1'b1;
            tick();
        end
        chk("over_no_ready", 64'(seen), 64'd0);
        chk("over_err",      64'(err),  64'd1);
        chk("over_done",     64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
